// File: rtl/seq_bin_to_bcd_pkg.sv
// -----------------------------------------------------------------------------
// seq_bin_to_bcd_pkg
//
// Shared definitions for the iterative binary-to-BCD converter:
//   - state_t    : FSM state encoding (ST_IDLE, ST_SHIFT)
//   - ADJ_THRESH : a BCD digit at or above this value is adjusted before a shift
//   - ADJ_VALUE  : amount added to such a digit so that the following doubling
//                  carries correctly into the next decimal digit
// -----------------------------------------------------------------------------
package seq_bin_to_bcd_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic [3:0] ADJ_THRESH = 4'd5;
    localparam logic [3:0] ADJ_VALUE  = 4'd3;

endpackage : seq_bin_to_bcd_pkg

// File: rtl/seq_bin_to_bcd_digit_adjust.sv
// -----------------------------------------------------------------------------
// bcd_digit_adjust
//
// Purely combinational add-3 correction for one BCD digit of the double-dabble
// scratch register. A digit of 5..9 becomes 8..12, so doubling it on the next
// shift produces the correct decimal carry into the digit above.
//
// Ports:
//   digit_in  [3:0]  scratch digit before the shift
//   digit_out [3:0]  digit_in + 3 when digit_in >= 5, otherwise digit_in
// -----------------------------------------------------------------------------
module bcd_digit_adjust
    import seq_bin_to_bcd_pkg::*;
(
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    // 4-bit add on purpose: a valid digit never exceeds 9, so 9+3=12 fits and
    // there is never a carry out of the digit.
    assign digit_out = (digit_in >= ADJ_THRESH) ? (digit_in + ADJ_VALUE) : digit_in;

endmodule : bcd_digit_adjust

// File: rtl/seq_bin_to_bcd.sv
// -----------------------------------------------------------------------------
// seq_bin_to_bcd
//
// Iterative (shift-add-3 / double-dabble) binary-to-BCD converter. One
// iteration per enabled clock; a conversion of a WIDTH-bit value takes WIDTH
// enabled cycles after the start request is accepted. The last result is held
// on bcd until the next conversion completes.
//
// Parameters:
//   WIDTH  : binary input width
//   DIGITS : number of BCD digits produced (10**DIGITS must exceed 2**WIDTH-1)
//   CNT_W  : iteration counter width (2**CNT_W must exceed WIDTH)
//
// Ports:
//   clk    : system clock, rising edge
//   reset  : synchronous, active-low reset; overrides en and start
//   en     : clock enable; when low every register holds
//   start  : conversion request, honoured only in IDLE with en high
//   bin    : unsigned value to convert, captured when start is accepted
//   busy   : high while a conversion is in flight
//   done   : one-enabled-cycle pulse when bcd has just been updated
//   bcd    : result, digit k (k=0 is units) on bcd[4k+3:4k]
// -----------------------------------------------------------------------------
module seq_bin_to_bcd
    import seq_bin_to_bcd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5,
    parameter int CNT_W  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int SCR_W = 4 * DIGITS;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t                 state_reg;
    logic [WIDTH-1:0]       shift_reg;
    logic [SCR_W-1:0]       scratch_reg;
    logic [CNT_W-1:0]       count_reg;
    logic [SCR_W-1:0]       bcd_reg;
    logic                   busy_reg;
    logic                   done_reg;

    // -------------------------------------------------------------------------
    // One double-dabble iteration, computed combinationally from the current
    // scratch and shift registers.
    // -------------------------------------------------------------------------
    logic [SCR_W-1:0]       adjusted;
    logic [SCR_W+WIDTH-1:0] joined_shifted;
    logic [SCR_W-1:0]       scratch_next;
    logic [WIDTH-1:0]       shift_next;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adjust
            bcd_digit_adjust u_adjust (
                .digit_in  (scratch_reg[4*gi +: 4]),
                .digit_out (adjusted[4*gi +: 4])
            );
        end
    endgenerate

    // Shifting the whole {scratch, shift} word moves the binary MSB into the
    // units digit LSB. The top bit of the adjusted scratch falls off; it is
    // always zero as long as DIGITS is large enough for WIDTH.
    assign joined_shifted = {adjusted, shift_reg} << 1;
    assign scratch_next   = joined_shifted[SCR_W+WIDTH-1:WIDTH];
    assign shift_next     = joined_shifted[WIDTH-1:0];

    // -------------------------------------------------------------------------
    // FSM, datapath and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            shift_reg   <= '0;
            scratch_reg <= '0;
            count_reg   <= '0;
            bcd_reg     <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else if (en) begin
            // done is a pulse: cleared on every enabled edge unless this edge
            // finishes a conversion. With en low it simply holds.
            done_reg <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        shift_reg   <= bin;
                        scratch_reg <= '0;
                        count_reg   <= CNT_LOAD;
                        busy_reg    <= 1'b1;
                        state_reg   <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    shift_reg   <= shift_next;
                    scratch_reg <= scratch_next;
                    count_reg   <= count_reg - CNT_ONE;
                    if (count_reg == CNT_ONE) begin
                        // Last iteration: publish the post-shift digits directly
                        // so bcd and done appear together on the next cycle.
                        bcd_reg   <= scratch_next;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign bcd  = bcd_reg;

endmodule : seq_bin_to_bcd

// File: tb/tb_seq_bin_to_bcd.sv
// -----------------------------------------------------------------------------
// tb_seq_bin_to_bcd
//
// Self-checking bench for seq_bin_to_bcd. Expected digits come from a decimal
// reference built with divide/modulo arithmetic; timing expectations come from
// the start/busy/done handshake rules.
// -----------------------------------------------------------------------------
module tb_seq_bin_to_bcd;

    localparam int WIDTH  = 16;
    localparam int DIGITS = 5;
    localparam int CNT_W  = 5;

    logic                  clk;
    logic                  reset;
    logic                  en;
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;

    int tests;
    int fails;

    seq_bin_to_bcd #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS),
        .CNT_W  (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decimal reference: peel digits off with /10 and %10.
    function automatic logic [4*DIGITS-1:0] ref_bcd(input int unsigned value);
        logic [4*DIGITS-1:0] r;
        int unsigned v;
        r = '0;
        v = value;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a start and return right after the accepting edge (E0 + 1).
    task automatic issue_start(input logic [WIDTH-1:0] value);
        bin   = value;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Plain conversion with en high: checks latency, busy width, single done
    // pulse and digits.
    task automatic run_plain(input string name, input logic [WIDTH-1:0] value);
        int lat;
        int dones;
        int busy_cnt;
        logic [4*DIGITS-1:0] exp_bcd;
        logic [4*DIGITS-1:0] got_bcd;
        exp_bcd  = ref_bcd(int'(value));
        lat      = -1;
        dones    = 0;
        busy_cnt = 0;
        got_bcd  = '0;
        issue_start(value);
        for (int k = 0; k <= 30; k++) begin
            if (busy) busy_cnt++;
            if (done) begin
                dones++;
                if (lat < 0) begin
                    lat = k;
                    got_bcd = bcd;
                end
            end
            bin = WIDTH'($urandom);   // must not disturb the conversion
            if (k < 30) step();
        end
        tests++;
        if (lat != WIDTH) begin
            fails++;
            $display("FAIL %s latency: got %0d edges, expected %0d", name, lat, WIDTH);
        end
        tests++;
        if (got_bcd !== exp_bcd) begin
            fails++;
            $display("FAIL %s bcd: got %h, expected %h", name, got_bcd, exp_bcd);
        end
        tests++;
        if (dones != 1) begin
            fails++;
            $display("FAIL %s done_pulses: got %0d, expected 1", name, dones);
        end
        tests++;
        if (busy_cnt != WIDTH) begin
            fails++;
            $display("FAIL %s busy_cycles: got %0d, expected %0d", name, busy_cnt, WIDTH);
        end
        tests++;
        if (bcd !== exp_bcd) begin
            fails++;
            $display("FAIL %s bcd_hold: got %h, expected %h", name, bcd, exp_bcd);
        end
        $display("[TB] %s bin=%0d bcd=%h latency=%0d", name, value, got_bcd, lat);
    endtask

    task automatic test_reset();
        en    = 1'b0;    // reset must win over en=0
        start = 1'b1;
        bin   = 16'd1234;
        reset = 1'b0;
        repeat (3) step();
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_busy: got %b, expected 0", busy);
        end
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL reset_done: got %b, expected 0", done);
        end
        tests++;
        if (bcd !== '0) begin
            fails++;
            $display("FAIL reset_bcd: got %h, expected 00000", bcd);
        end
        start = 1'b0;
        en    = 1'b1;
        reset = 1'b1;
        step();
        $display("[TB] reset busy=%b done=%b bcd=%h", busy, done, bcd);
    endtask

    task automatic test_known();
        run_plain("zero", 16'd0);
        run_plain("max", 16'd65535);
        run_plain("v12345", 16'd12345);
        run_plain("v9", 16'd9);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            run_plain("random", WIDTH'($urandom_range(0, 65535)));
        end
    endtask

    task automatic test_start_while_busy();
        int lat;
        int dones;
        logic [4*DIGITS-1:0] got_bcd;
        lat = -1;
        dones = 0;
        got_bcd = '0;
        issue_start(16'd1000);
        for (int k = 0; k <= 40; k++) begin
            if (done) begin
                dones++;
                if (lat < 0) begin
                    lat = k;
                    got_bcd = bcd;
                end
            end
            if (k == 4) begin
                bin = 16'd42;
                start = 1'b1;     // sampled at edge E0+5 while busy
            end else begin
                start = 1'b0;
            end
            if (k < 40) step();
        end
        tests++;
        if (got_bcd !== 20'h01000) begin
            fails++;
            $display("FAIL ignore_start bcd: got %h, expected 01000", got_bcd);
        end
        tests++;
        if (dones != 1 || lat != WIDTH) begin
            fails++;
            $display("FAIL ignore_start done: got %0d pulses at %0d, expected 1 at %0d",
                     dones, lat, WIDTH);
        end
        $display("[TB] start_while_busy bcd=%h pulses=%0d", got_bcd, dones);
    endtask

    task automatic test_reset_abort();
        int dones;
        dones = 0;
        issue_start(16'd4321);
        repeat (7) step();       // now just after edge E0+7
        reset = 1'b0;            // sampled at edge E0+8
        step();
        tests++;
        if (busy !== 1'b0 || bcd !== '0 || done !== 1'b0) begin
            fails++;
            $display("FAIL abort_state: got busy=%b done=%b bcd=%h, expected 0 0 00000",
                     busy, done, bcd);
        end
        reset = 1'b1;
        for (int k = 0; k < 25; k++) begin
            if (done) dones++;
            step();
        end
        tests++;
        if (dones != 0 || bcd !== '0) begin
            fails++;
            $display("FAIL abort_no_done: got %0d pulses bcd=%h, expected 0 and 00000", dones, bcd);
        end
        $display("[TB] reset_abort pulses=%0d bcd=%h", dones, bcd);
        run_plain("after_abort", 16'd77);
    endtask

    task automatic test_stall();
        int lat;
        logic [4*DIGITS-1:0] got_bcd;
        lat = -1;
        got_bcd = '0;
        issue_start(16'd500);
        for (int k = 0; k <= 40 && lat < 0; k++) begin
            if (done) begin
                lat = k;
                got_bcd = bcd;
            end else begin
                if (k == 3)  en = 1'b0;   // edges E0+4..E0+10 stalled
                if (k == 10) en = 1'b1;
                step();
            end
        end
        en = 1'b1;
        tests++;
        if (lat != WIDTH + 7) begin
            fails++;
            $display("FAIL stall_latency: got %0d, expected %0d", lat, WIDTH + 7);
        end
        tests++;
        if (got_bcd !== 20'h00500) begin
            fails++;
            $display("FAIL stall_bcd: got %h, expected 00500", got_bcd);
        end
        // done must persist while en is low, then clear on the next enabled edge
        en = 1'b0;
        repeat (3) step();
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL stall_done_hold: got %b, expected 1", done);
        end
        en = 1'b1;
        step();
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL stall_done_clear: got %b, expected 0", done);
        end
        $display("[TB] stall bin=500 latency=%0d bcd=%h", lat, got_bcd);
    endtask

    task automatic test_back_to_back();
        int lat;
        int ok;
        logic [4*DIGITS-1:0] got_bcd;
        ok = 0;
        issue_start(16'd250);
        for (int k = 0; k <= 30 && ok == 0; k++) begin
            if (done) ok = 1;
            else step();
        end
        tests++;
        if (ok == 0 || bcd !== 20'h00250) begin
            fails++;
            $display("FAIL b2b_first: got done=%0d bcd=%h, expected 1 and 00250", ok, bcd);
        end
        // start in the done cycle
        issue_start(16'd999);
        lat = -1;
        got_bcd = '0;
        for (int k = 0; k <= 30 && lat < 0; k++) begin
            if (done) begin
                lat = k;
                got_bcd = bcd;
            end else begin
                if (k == 8) begin
                    tests++;
                    if (bcd !== 20'h00250) begin
                        fails++;
                        $display("FAIL b2b_hold: got %h, expected 00250", bcd);
                    end
                end
                step();
            end
        end
        tests++;
        if (lat != WIDTH || got_bcd !== 20'h00999) begin
            fails++;
            $display("FAIL b2b_second: got lat=%0d bcd=%h, expected %0d and 00999",
                     lat, got_bcd, WIDTH);
        end
        $display("[TB] back_to_back second bcd=%h latency=%0d", got_bcd, lat);
        step();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        en    = 1'b1;
        start = 1'b0;
        bin   = '0;
        step();
        test_reset();
        test_known();
        test_random();
        test_start_while_busy();
        test_reset_abort();
        test_stall();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_seq_bin_to_bcd
